// File: rtl/rv_frontend.sv
// RV32I front end: PC / instruction fetch register, registered decoder and a
// 32x32 register file with two registered read ports and one write port.
`timescale 1ns/1ps
module rv_frontend #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_target,
    input  logic        i_pc_select,
    input  logic        i_pc_inc,
    input  logic        i_data_latch,
    input  logic [31:0] i_instruction,
    input  logic [4:0]  i_rd,
    input  logic        i_write,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_instr,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [31:0] o_imm_i,
    output logic [31:0] o_imm_u,
    output logic [31:0] o_imm_j,
    output logic [31:0] o_imm_b,
    output logic [31:0] o_imm_s,
    output logic [2:0]  o_funct3,
    output logic [10:0] o_alu_ctrl,
    output logic [1:0]  o_res_src,
    output logic        o_op1_pc,
    output logic [3:0]  o_op2_sel,
    output logic        o_reg_write,
    output logic        o_inst_jalr,
    output logic        o_inst_jal,
    output logic        o_inst_branch,
    output logic        o_inst_store,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // ALU control for OP / OP-IMM; sub_en is only ever set for register-register ops
    function automatic logic [10:0] alu_op_f(input logic [2:0] funct3,
                                             input logic sub_en,
                                             input logic arith_en);
        logic [10:0] ctrl;
        ctrl = 11'b0;
        case (funct3)
            3'b000:  ctrl[0] = sub_en;
            3'b001:  ctrl[1] = 1'b1;
            3'b010:  begin ctrl[4] = 1'b1; ctrl[7] = 1'b1; end
            3'b011:  begin ctrl[4] = 1'b1; ctrl[8] = 1'b1; end
            3'b100:  begin ctrl[5] = 1'b1; ctrl[9] = 1'b1; end
            3'b101:  begin ctrl[2] = 1'b1; ctrl[3] = arith_en; end
            3'b110:  begin ctrl[5] = 1'b1; ctrl[10] = 1'b1; end
            3'b111:  ctrl[5] = 1'b1;
            default: ctrl = 11'b0;
        endcase
        return ctrl;
    endfunction

    function automatic logic [10:0] branch_op_f(input logic [2:0] funct3);
        logic [10:0] ctrl;
        ctrl    = 11'b0;
        ctrl[4] = 1'b1;
        ctrl[6] = funct3[0];
        case (funct3[2:1])
            2'b10:   ctrl[7] = 1'b1;
            2'b11:   ctrl[8] = 1'b1;
            default: ctrl[8:7] = 2'b00;
        endcase
        return ctrl;
    endfunction

    logic [31:0] instr_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_s_s;
    logic [10:0] alu_ctrl_s;
    logic [1:0]  res_src_s;
    logic        op1_pc_s;
    logic [3:0]  op2_sel_s;
    logic        reg_write_s;
    logic        jalr_s;
    logic        jal_s;
    logic        branch_s;
    logic        store_s;
    logic [31:0] regs_r [32];

    // Fetch: PC advance and instruction capture are independent strobes
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_fetch_pc    <= RESET_ADDR;
            o_fetch_instr <= 32'h0000_0013;
        end else begin
            if (i_pc_inc) begin
                o_fetch_pc <= i_pc_select ? i_pc_target : (o_fetch_pc + 32'd4);
            end
            if (i_data_latch) begin
                o_fetch_instr <= i_instruction;
            end
        end
    end

    // Decode of the fetched word; fields and immediates are produced for every opcode
    always_comb begin
        instr_s     = o_fetch_instr;
        rs1_s       = instr_s[19:15];
        rs2_s       = 5'd0;
        imm_i_s     = {{20{instr_s[31]}}, instr_s[31:20]};
        imm_u_s     = {instr_s[31:12], 12'h000};
        imm_j_s     = {{12{instr_s[31]}}, instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
        imm_b_s     = {{20{instr_s[31]}}, instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
        imm_s_s     = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
        alu_ctrl_s  = 11'b0;
        res_src_s   = 2'b00;
        op1_pc_s    = 1'b0;
        op2_sel_s   = 4'b0000;
        reg_write_s = 1'b0;
        jalr_s      = 1'b0;
        jal_s       = 1'b0;
        branch_s    = 1'b0;
        store_s     = 1'b0;
        case (instr_s[6:0])
            OPC_OP: begin
                alu_ctrl_s  = alu_op_f(instr_s[14:12], instr_s[30], instr_s[30]);
                rs2_s       = instr_s[24:20];
                reg_write_s = 1'b1;
            end
            OPC_OPIMM: begin
                alu_ctrl_s  = alu_op_f(instr_s[14:12], 1'b0, instr_s[30]);
                op2_sel_s   = 4'b0001;
                reg_write_s = 1'b1;
            end
            OPC_LUI: begin
                rs1_s       = 5'd0;
                op2_sel_s   = 4'b0010;
                reg_write_s = 1'b1;
            end
            OPC_AUIPC: begin
                rs1_s       = 5'd0;
                op1_pc_s    = 1'b1;
                op2_sel_s   = 4'b0010;
                reg_write_s = 1'b1;
            end
            OPC_JAL: begin
                rs1_s       = 5'd0;
                jal_s       = 1'b1;
                op1_pc_s    = 1'b1;
                res_src_s   = 2'b10;
                reg_write_s = 1'b1;
            end
            OPC_JALR: begin
                jalr_s      = 1'b1;
                res_src_s   = 2'b10;
                reg_write_s = 1'b1;
            end
            OPC_BRANCH: begin
                branch_s   = 1'b1;
                alu_ctrl_s = branch_op_f(instr_s[14:12]);
                rs2_s      = instr_s[24:20];
            end
            OPC_LOAD: begin
                op2_sel_s   = 4'b0001;
                res_src_s   = 2'b01;
                reg_write_s = 1'b1;
            end
            OPC_STORE: begin
                op2_sel_s = 4'b1000;
                store_s   = 1'b1;
                rs2_s     = instr_s[24:20];
            end
            default: begin
                alu_ctrl_s = 11'b0;
            end
        endcase
    end

    // Decode pipeline register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_pc          <= 32'h0;
            o_rs1         <= 5'd0;
            o_rs2         <= 5'd0;
            o_rd          <= 5'd0;
            o_imm_i       <= 32'h0;
            o_imm_u       <= 32'h0;
            o_imm_j       <= 32'h0;
            o_imm_b       <= 32'h0;
            o_imm_s       <= 32'h0;
            o_funct3      <= 3'd0;
            o_alu_ctrl    <= 11'b0;
            o_res_src     <= 2'b00;
            o_op1_pc      <= 1'b0;
            o_op2_sel     <= 4'b0000;
            o_reg_write   <= 1'b0;
            o_inst_jalr   <= 1'b0;
            o_inst_jal    <= 1'b0;
            o_inst_branch <= 1'b0;
            o_inst_store  <= 1'b0;
        end else begin
            o_pc          <= o_fetch_pc;
            o_rs1         <= rs1_s;
            o_rs2         <= rs2_s;
            o_rd          <= instr_s[11:7];
            o_imm_i       <= imm_i_s;
            o_imm_u       <= imm_u_s;
            o_imm_j       <= imm_j_s;
            o_imm_b       <= imm_b_s;
            o_imm_s       <= imm_s_s;
            o_funct3      <= instr_s[14:12];
            o_alu_ctrl    <= alu_ctrl_s;
            o_res_src     <= res_src_s;
            o_op1_pc      <= op1_pc_s;
            o_op2_sel     <= op2_sel_s;
            o_reg_write   <= reg_write_s;
            o_inst_jalr   <= jalr_s;
            o_inst_jal    <= jal_s;
            o_inst_branch <= branch_s;
            o_inst_store  <= store_s;
        end
    end

    // Register file write port; x0 is never written
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0;
            end
        end else if (i_write && (i_rd != 5'd0)) begin
            regs_r[i_rd] <= i_wdata;
        end
    end

    // Registered read ports see the pre-write contents on a same-edge write
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rdata1 <= 32'h0;
            o_rdata2 <= 32'h0;
        end else begin
            o_rdata1 <= (o_rs1 == 5'd0) ? 32'h0 : regs_r[o_rs1];
            o_rdata2 <= (o_rs2 == 5'd0) ? 32'h0 : regs_r[o_rs2];
        end
    end

endmodule

// File: tb/tb_rv_frontend.sv
// Bench for rv_frontend: directed vector table, hand-written fetch/regfile
// sequences and randomized traffic against a behavioural reference model.
`timescale 1ns/1ps
module tb_rv_frontend;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [10:0] A_SUB = 11'h001, A_SHL = 11'h002, A_SHR = 11'h004, A_SRA = 11'h008;
    localparam logic [10:0] A_CMP = 11'h010, A_BITS = 11'h020, A_INV = 11'h040, A_LTS = 11'h080;
    localparam logic [10:0] A_LTU = 11'h100, A_XOR = 11'h200, A_OR = 11'h400;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm_i, imm_u, imm_j, imm_b, imm_s;
        logic [2:0]  f3;
        logic [10:0] alu;
        logic [1:0]  res_src;
        logic        op1_pc;
        logic [3:0]  op2_sel;
        logic        reg_write, jalr, jal, branch, store;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs1, rs2, rd;
        logic [10:0] alu;
        logic [1:0]  res_src;
        logic        op1_pc;
        logic [3:0]  op2_sel;
        logic [4:0]  flags;   // {reg_write, jalr, jal, branch, store}
        int          kind;    // 0 I, 1 U, 2 J, 3 B, 4 S
        logic [31:0] imm;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_reset, i_pc_select, i_pc_inc, i_data_latch, i_write;
    logic [31:0] i_pc_target, i_instruction, i_wdata;
    logic [4:0]  i_rd;
    logic [31:0] o_fetch_pc, o_fetch_instr, o_pc, o_imm_i, o_imm_u, o_imm_j, o_imm_b, o_imm_s;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [2:0]  o_funct3;
    logic [10:0] o_alu_ctrl;
    logic [1:0]  o_res_src;
    logic        o_op1_pc, o_reg_write, o_inst_jalr, o_inst_jal, o_inst_branch, o_inst_store;
    logic [3:0]  o_op2_sel;
    logic [31:0] o_rdata1, o_rdata2;

    int unsigned n_total = 0;
    int unsigned n_bad = 0;

    always #5 i_clk = ~i_clk;

    rv_frontend #(.RESET_ADDR(RST_PC)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_pc_target(i_pc_target), .i_pc_select(i_pc_select),
        .i_pc_inc(i_pc_inc), .i_data_latch(i_data_latch), .i_instruction(i_instruction),
        .i_rd(i_rd), .i_write(i_write), .i_wdata(i_wdata),
        .o_fetch_pc(o_fetch_pc), .o_fetch_instr(o_fetch_instr), .o_pc(o_pc),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
        .o_imm_i(o_imm_i), .o_imm_u(o_imm_u), .o_imm_j(o_imm_j), .o_imm_b(o_imm_b), .o_imm_s(o_imm_s),
        .o_funct3(o_funct3), .o_alu_ctrl(o_alu_ctrl), .o_res_src(o_res_src), .o_op1_pc(o_op1_pc),
        .o_op2_sel(o_op2_sel), .o_reg_write(o_reg_write), .o_inst_jalr(o_inst_jalr),
        .o_inst_jal(o_inst_jal), .o_inst_branch(o_inst_branch), .o_inst_store(o_inst_store),
        .o_rdata1(o_rdata1), .o_rdata2(o_rdata2)
    );

    dec_t got_dec;
    assign got_dec = {o_pc, o_rs1, o_rs2, o_rd, o_imm_i, o_imm_u, o_imm_j, o_imm_b, o_imm_s,
                      o_funct3, o_alu_ctrl, o_res_src, o_op1_pc, o_op2_sel,
                      o_reg_write, o_inst_jalr, o_inst_jal, o_inst_branch, o_inst_store};

    // Reference decoder written from the ISA rules (mnemonic level)
    function automatic dec_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        dec_t d;
        logic signed [31:0] s;
        logic [31:0] sra20, sra19, sra11;
        logic [6:0] opc;
        logic [2:0] f3;
        s = ins;
        sra20 = s >>> 20;
        sra19 = s >>> 19;
        sra11 = s >>> 11;
        opc = ins[6:0];
        f3 = ins[14:12];
        d = '0;
        d.pc = pc;
        d.rd = ins[11:7];
        d.rs1 = ins[19:15];
        d.f3 = f3;
        d.imm_i = sra20;
        d.imm_u = ins & 32'hFFFF_F000;
        d.imm_s = (sra20 & 32'hFFFF_FFE0) | {27'd0, ins[11:7]};
        d.imm_b = (sra19 & 32'hFFFF_F000) | ({31'd0, ins[7]} << 11) | ({26'd0, ins[30:25]} << 5)
                | ({28'd0, ins[11:8]} << 1);
        d.imm_j = (sra11 & 32'hFFF0_0000) | (ins & 32'h000F_F000) | ({31'd0, ins[20]} << 11)
                | ({22'd0, ins[30:21]} << 1);
        case (opc)
            7'h33, 7'h13: begin
                d.reg_write = 1'b1;
                if (opc == 7'h13) d.op2_sel = 4'b0001;
                case (f3)
                    3'd0: d.alu = (opc == 7'h33 && ins[30]) ? A_SUB : 11'h000;
                    3'd1: d.alu = A_SHL;
                    3'd2: d.alu = A_CMP | A_LTS;
                    3'd3: d.alu = A_CMP | A_LTU;
                    3'd4: d.alu = A_BITS | A_XOR;
                    3'd5: d.alu = ins[30] ? (A_SHR | A_SRA) : A_SHR;
                    3'd6: d.alu = A_BITS | A_OR;
                    default: d.alu = A_BITS;
                endcase
            end
            7'h37: begin d.op2_sel = 4'b0010; d.reg_write = 1'b1; d.rs1 = 5'd0; end
            7'h17: begin d.op1_pc = 1'b1; d.op2_sel = 4'b0010; d.reg_write = 1'b1; d.rs1 = 5'd0; end
            7'h6F: begin d.jal = 1'b1; d.op1_pc = 1'b1; d.res_src = 2'b10; d.reg_write = 1'b1; d.rs1 = 5'd0; end
            7'h67: begin d.jalr = 1'b1; d.res_src = 2'b10; d.reg_write = 1'b1; end
            7'h63: begin
                d.branch = 1'b1;
                d.alu = A_CMP | (f3[2] ? (f3[1] ? A_LTU : A_LTS) : 11'h000) | (f3[0] ? A_INV : 11'h000);
            end
            7'h03: begin d.op2_sel = 4'b0001; d.res_src = 2'b01; d.reg_write = 1'b1; end
            7'h23: begin d.op2_sel = 4'b1000; d.store = 1'b1; end
            default: d.alu = 11'h000;
        endcase
        if (opc == 7'h33 || opc == 7'h23 || opc == 7'h63) d.rs2 = ins[24:20];
        return d;
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    vec_t vecs[$];
    logic [31:0] m_pc, m_instr, m_rd1, m_rd2;
    logic [31:0] m_regs [32];
    dec_t m_dec;

    initial begin
        logic [31:0] imm_got;
        logic [255:0] gp, ep;
        logic [31:0] ins;
        logic rst;

        vecs.push_back('{32'hFFF0_0093, 5'd0, 5'd0, 5'd1, 11'h000, 2'd0, 1'b0, 4'b0001, 5'b10000, 0, 32'hFFFF_FFFF});
        vecs.push_back('{32'h4020_8033, 5'd1, 5'd2, 5'd0, 11'h001, 2'd0, 1'b0, 4'b0000, 5'b10000, 0, 32'h0000_0402});
        vecs.push_back('{32'h0020_D463, 5'd1, 5'd2, 5'd8, 11'h0D0, 2'd0, 1'b0, 4'b0000, 5'b00010, 3, 32'h0000_0008});
        vecs.push_back('{32'h0020_9463, 5'd1, 5'd2, 5'd8, 11'h050, 2'd0, 1'b0, 4'b0000, 5'b00010, 3, 32'h0000_0008});
        vecs.push_back('{32'h0020_C463, 5'd1, 5'd2, 5'd8, 11'h090, 2'd0, 1'b0, 4'b0000, 5'b00010, 3, 32'h0000_0008});
        vecs.push_back('{32'h0000_006F, 5'd0, 5'd0, 5'd0, 11'h000, 2'd2, 1'b1, 4'b0000, 5'b10100, 2, 32'h0000_0000});
        vecs.push_back('{32'h1234_50B7, 5'd0, 5'd0, 5'd1, 11'h000, 2'd0, 1'b0, 4'b0010, 5'b10000, 1, 32'h1234_5000});
        vecs.push_back('{32'h0000_1117, 5'd0, 5'd0, 5'd2, 11'h000, 2'd0, 1'b1, 4'b0010, 5'b10000, 1, 32'h0000_1000});
        vecs.push_back('{32'h0040_A183, 5'd1, 5'd0, 5'd3, 11'h000, 2'd1, 1'b0, 4'b0001, 5'b10000, 0, 32'h0000_0004});
        vecs.push_back('{32'h0020_A423, 5'd1, 5'd2, 5'd8, 11'h000, 2'd0, 1'b0, 4'b1000, 5'b00001, 4, 32'h0000_0008});
        vecs.push_back('{32'h0002_80E7, 5'd5, 5'd0, 5'd1, 11'h000, 2'd2, 1'b0, 4'b0000, 5'b11000, 0, 32'h0000_0000});
        vecs.push_back('{32'h4011_D193, 5'd3, 5'd0, 5'd3, 11'h00C, 2'd0, 1'b0, 4'b0001, 5'b10000, 0, 32'h0000_0401});
        vecs.push_back('{32'h0020_B233, 5'd1, 5'd2, 5'd4, 11'h110, 2'd0, 1'b0, 4'b0000, 5'b10000, 0, 32'h0000_0002});
        vecs.push_back('{32'h0FF0_E093, 5'd1, 5'd0, 5'd1, 11'h420, 2'd0, 1'b0, 4'b0001, 5'b10000, 0, 32'h0000_00FF});
        vecs.push_back('{32'hFFFF_FFFF, 5'd31, 5'd0, 5'd31, 11'h000, 2'd0, 1'b0, 4'b0000, 5'b00000, 0, 32'hFFFF_FFFF});

        i_reset = 1'b1; i_pc_select = 1'b0; i_pc_inc = 1'b0; i_data_latch = 1'b0; i_write = 1'b0;
        i_pc_target = 32'h0; i_instruction = 32'h0; i_wdata = 32'h0; i_rd = 5'd0;
        tick();
        tick();
        check("rst_pc", 256'(o_fetch_pc), 256'(RST_PC));
        check("rst_instr", 256'(o_fetch_instr), 256'(32'h0000_0013));
        check("rst_dec", 256'(got_dec), 256'(0));
        check("rst_rdata", 256'({o_rdata1, o_rdata2}), 256'(0));

        i_reset = 1'b0;
        i_pc_inc = 1'b1;
        tick(); tick(); tick();
        i_pc_inc = 1'b0;
        check("pc_inc3", 256'(o_fetch_pc), 256'(32'h0000_010C));
        i_pc_inc = 1'b1; i_pc_select = 1'b1; i_pc_target = 32'h0000_0040;
        tick();
        i_pc_inc = 1'b0; i_pc_select = 1'b0;
        check("pc_jump", 256'(o_fetch_pc), 256'(32'h0000_0040));

        for (int k = 0; k < vecs.size(); k++) begin
            i_instruction = vecs[k].instr; i_data_latch = 1'b1;
            tick();
            i_data_latch = 1'b0;
            tick();
            case (vecs[k].kind)
                1: imm_got = o_imm_u;
                2: imm_got = o_imm_j;
                3: imm_got = o_imm_b;
                4: imm_got = o_imm_s;
                default: imm_got = o_imm_i;
            endcase
            gp = 256'({o_rs1, o_rs2, o_rd, o_alu_ctrl, o_res_src, o_op1_pc, o_op2_sel,
                       o_reg_write, o_inst_jalr, o_inst_jal, o_inst_branch, o_inst_store, imm_got, o_pc});
            ep = 256'({vecs[k].rs1, vecs[k].rs2, vecs[k].rd, vecs[k].alu, vecs[k].res_src, vecs[k].op1_pc,
                       vecs[k].op2_sel, vecs[k].flags, vecs[k].imm, 32'h0000_0040});
            check($sformatf("vec%0d", k), gp, ep);
            check($sformatf("vec%0d_model", k), 256'(got_dec), 256'(model_decode(vecs[k].instr, 32'h0000_0040)));
        end

        // register file: write, read back, same-edge old value, x0 and rs2 port
        i_write = 1'b1; i_rd = 5'd5; i_wdata = 32'hDEAD_BEEF;
        i_instruction = 32'h0002_8013; i_data_latch = 1'b1;
        tick();
        i_write = 1'b0; i_data_latch = 1'b0;
        tick(); tick();
        check("rf_x5", 256'(o_rdata1), 256'(32'hDEAD_BEEF));
        i_write = 1'b1; i_rd = 5'd5; i_wdata = 32'h1234_5678;
        tick();
        i_write = 1'b0;
        check("rf_same_cycle_old", 256'(o_rdata1), 256'(32'hDEAD_BEEF));
        tick();
        check("rf_same_cycle_new", 256'(o_rdata1), 256'(32'h1234_5678));
        i_write = 1'b1; i_rd = 5'd0; i_wdata = 32'h0000_0001;
        i_instruction = 32'h0000_0033; i_data_latch = 1'b1;
        tick();
        i_write = 1'b0; i_data_latch = 1'b0;
        tick(); tick();
        check("rf_x0", 256'({o_rdata1, o_rdata2}), 256'(0));
        i_write = 1'b1; i_rd = 5'd6; i_wdata = 32'hA5A5_0F0F;
        i_instruction = 32'h0060_0033; i_data_latch = 1'b1;
        tick();
        i_write = 1'b0; i_data_latch = 1'b0;
        tick(); tick();
        check("rf_rs2", 256'(o_rdata2), 256'(32'hA5A5_0F0F));

        // reset beats simultaneous pc_inc, latch and write
        i_reset = 1'b1; i_pc_inc = 1'b1; i_pc_select = 1'b1; i_pc_target = 32'h0000_0200;
        i_data_latch = 1'b1; i_instruction = 32'h0002_8013; i_write = 1'b1; i_rd = 5'd5; i_wdata = 32'h77;
        tick();
        i_reset = 1'b0; i_pc_inc = 1'b0; i_pc_select = 1'b0; i_write = 1'b0;
        check("rst_override_pc", 256'({o_fetch_pc, o_fetch_instr}), 256'({RST_PC, 32'h0000_0013}));
        tick();
        i_data_latch = 1'b0;
        tick(); tick();
        check("rst_override_rf", 256'(o_rdata1), 256'(0));

        // randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            rst = (c == 0) || ($urandom_range(0, 39) == 0);
            ins = $urandom;
            case ($urandom_range(0, 9))
                0: ins[6:0] = 7'h33;
                1: ins[6:0] = 7'h13;
                2: ins[6:0] = 7'h37;
                3: ins[6:0] = 7'h17;
                4: ins[6:0] = 7'h6F;
                5: ins[6:0] = 7'h67;
                6: ins[6:0] = 7'h63;
                7: ins[6:0] = 7'h03;
                8: ins[6:0] = 7'h23;
                default: ins[1:0] = ins[1:0];
            endcase
            if (ins[6:0] == 7'h63 && ins[14:13] == 2'b01) ins[14:12] = 3'b000;
            if ($urandom_range(0, 3) != 0) begin ins[19:18] = 2'b00; ins[24:23] = 2'b00; end
            i_reset = rst;
            i_instruction = ins;
            i_data_latch = 1'($urandom_range(0, 1));
            i_pc_inc = 1'($urandom_range(0, 1));
            i_pc_select = ($urandom_range(0, 3) == 0);
            i_pc_target = $urandom;
            i_write = 1'($urandom_range(0, 1));
            i_rd = 5'($urandom_range(0, 7));
            i_wdata = $urandom;
            if (rst) begin
                m_pc = RST_PC; m_instr = 32'h0000_0013; m_dec = '0; m_rd1 = 32'h0; m_rd2 = 32'h0;
                for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
            end else begin
                m_rd1 = (m_dec.rs1 == 5'd0) ? 32'h0 : m_regs[m_dec.rs1];
                m_rd2 = (m_dec.rs2 == 5'd0) ? 32'h0 : m_regs[m_dec.rs2];
                m_dec = model_decode(m_instr, m_pc);
                if (i_write && i_rd != 5'd0) m_regs[i_rd] = i_wdata;
                if (i_pc_inc) m_pc = i_pc_select ? i_pc_target : m_pc + 32'd4;
                if (i_data_latch) m_instr = i_instruction;
            end
            tick();
            check($sformatf("rnd%0d_pc", c), 256'(o_fetch_pc), 256'(m_pc));
            check($sformatf("rnd%0d_instr", c), 256'(o_fetch_instr), 256'(m_instr));
            check($sformatf("rnd%0d_dec", c), 256'(got_dec), 256'(m_dec));
            check($sformatf("rnd%0d_rdata", c), 256'({o_rdata1, o_rdata2}), 256'({m_rd1, m_rd2}));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
